// File: rtl/pulse_tracer_multi.sv
// ----------------------------------------------------------------------------
// pulse_tracer_multi
//
// Multi-channel edge tracer for asynchronous, noisy inputs. Each channel runs
// through its own synchroniser chain, then a stability debounce filter. When
// the filtered level changes, an edge-mode selector decides whether that
// change raises a one-cycle event pulse and sets a sticky event flag.
//
// Optional feature (compile-time macro): PULSE_TRACER_STRETCH_EN
//   When defined, pulse_out[i] stays high for STRETCH_CYCLES cycles after a
//   qualifying event. A new qualifying event reloads the full width. When the
//   macro is undefined, pulse_out is exactly one cycle wide.
//
// Parameters:
//   NUM_CH          number of independent channels (>=1)
//   SYNC_STAGES     flops per synchroniser chain (>=2)
//   DEBOUNCE_CYCLES consecutive disagreeing samples before level_out moves (>=1)
//   STRETCH_CYCLES  stretched pulse width, used only with the macro (>=1)
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   noisy_in   in   [NUM_CH]   raw asynchronous inputs, bit i = channel i
//   edge_mode  in   [2*NUM_CH] per channel: 00 off, 01 rise, 10 fall, 11 both
//   evt_clr    in   [NUM_CH]   synchronous clear of evt_flag[i]
//   pulse_out  out  [NUM_CH]   registered event pulse
//   level_out  out  [NUM_CH]   debounced level
//   evt_flag   out  [NUM_CH]   sticky event flag (set beats clear)
// ----------------------------------------------------------------------------
module pulse_tracer_multi #(
    parameter int NUM_CH          = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int STRETCH_CYCLES  = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_CH-1:0]     noisy_in,
    input  logic [2*NUM_CH-1:0]   edge_mode,
    input  logic [NUM_CH-1:0]     evt_clr,
    output logic [NUM_CH-1:0]     pulse_out,
    output logic [NUM_CH-1:0]     level_out,
    output logic [NUM_CH-1:0]     evt_flag
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Elaboration-time guard against illegal parameter sets.
    if (NUM_CH < 1 || SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || STRETCH_CYCLES < 1) begin : g_param_check
        $error("pulse_tracer_multi: illegal parameter value");
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [SYNC_STAGES-1:0] r_sync;
            logic [CNT_W-1:0]       r_cnt;
            logic                   r_level;
            logic                   r_flag;
            logic                   w_sync;
            logic                   w_update;
            logic                   w_qual;
            logic [1:0]             w_mode;

            assign w_sync   = r_sync[SYNC_STAGES-1];
            assign w_mode   = edge_mode[2*gi +: 2];
            // The level flips on the DEBOUNCE_CYCLES-th consecutive disagreeing sample.
            assign w_update = (w_sync != r_level) && (r_cnt == CNT_LAST);
            // New level 1 means a rising event (mode bit 0), 0 means falling (mode bit 1).
            assign w_qual   = w_update && (w_sync ? w_mode[0] : w_mode[1]);

            // Bit 0 is the first stage; the top bit feeds the filter.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sync <= '0;
                end else begin
                    r_sync <= {r_sync[SYNC_STAGES-2:0], noisy_in[gi]};
                end
            end

            // Any agreeing sample restarts the count, so short glitches vanish.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt   <= '0;
                    r_level <= 1'b0;
                end else if (w_sync == r_level) begin
                    r_cnt   <= '0;
                end else if (w_update) begin
                    r_level <= w_sync;
                    r_cnt   <= '0;
                end else begin
                    r_cnt   <= r_cnt + CNT_W'(1);
                end
            end

            // A set at the same edge as a clear must win.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_flag <= 1'b0;
                end else if (w_qual) begin
                    r_flag <= 1'b1;
                end else if (evt_clr[gi]) begin
                    r_flag <= 1'b0;
                end
            end

`ifdef PULSE_TRACER_STRETCH_EN
            localparam int STR_W = $clog2(STRETCH_CYCLES + 1);
            logic [STR_W-1:0] r_stretch;

            // Down-counter; a fresh event reloads the full width.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_stretch <= '0;
                end else if (w_qual) begin
                    r_stretch <= STR_W'(STRETCH_CYCLES);
                end else if (r_stretch != '0) begin
                    r_stretch <= r_stretch - STR_W'(1);
                end
            end

            assign pulse_out[gi] = (r_stretch != '0);
`else
            logic r_pulse;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_pulse <= 1'b0;
                end else begin
                    r_pulse <= w_qual;
                end
            end

            assign pulse_out[gi] = r_pulse;
`endif

            assign level_out[gi] = r_level;
            assign evt_flag[gi]  = r_flag;
        end
    endgenerate

endmodule

// File: tb/tb_pulse_tracer_multi.sv
// ----------------------------------------------------------------------------
// tb_pulse_tracer_multi
//
// Directed sequence followed by a randomized phase. A reference model derives
// the expected outputs from the input history: a channel's level flips when
// the last DEBOUNCE_CYCLES synchronised samples (the input seen SYNC_STAGES
// edges earlier) all differ from the current level and lie after the previous
// flip. A pulse is high while an edge is within PW edges of the last
// qualifying event.
// ----------------------------------------------------------------------------
module tb_pulse_tracer_multi;

    localparam int NCH = 4;
    localparam int SS  = 2;
    localparam int DB  = 4;
    localparam int ST  = 3;
`ifdef PULSE_TRACER_STRETCH_EN
    localparam int PW  = ST;
`else
    localparam int PW  = 1;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NCH-1:0]   noisy_in;
    logic [2*NCH-1:0] edge_mode;
    logic [NCH-1:0]   evt_clr;
    logic [NCH-1:0]   pulse_out;
    logic [NCH-1:0]   level_out;
    logic [NCH-1:0]   evt_flag;

    pulse_tracer_multi #(
        .NUM_CH         (NCH),
        .SYNC_STAGES    (SS),
        .DEBOUNCE_CYCLES(DB),
        .STRETCH_CYCLES (ST)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .noisy_in (noisy_in),
        .edge_mode(edge_mode),
        .evt_clr  (evt_clr),
        .pulse_out(pulse_out),
        .level_out(level_out),
        .evt_flag (evt_flag)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [NCH-1:0] samp[$];   // samp[e-1] = noisy_in sampled at edge e
    int             ec;        // edges since reset release
    logic [NCH-1:0] m_lev;
    logic [NCH-1:0] m_flag;
    logic [NCH-1:0] m_pulse;
    int             lu[NCH];   // edge of last level flip (0 = reset)
    int             lq[NCH];   // edge of last qualifying event

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Synchronised value seen by the filter at edge e.
    function automatic logic s_at(input int e, input int c);
        if (e - SS < 1) return 1'b0;
        return samp[e-SS-1][c];
    endfunction

    task automatic model_reset();
        ec = 0;
        samp.delete();
        m_lev   = '0;
        m_flag  = '0;
        m_pulse = '0;
        for (int c = 0; c < NCH; c++) begin
            lu[c] = 0;
            lq[c] = -1000;
        end
    endtask

    task automatic model_edge();
        ec++;
        samp.push_back(noisy_in);
        for (int c = 0; c < NCH; c++) begin
            bit all_diff;
            bit qual;
            all_diff = (ec - lu[c] >= DB);
            for (int j = 0; j < DB; j++)
                if (all_diff && s_at(ec - j, c) == m_lev[c]) all_diff = 1'b0;
            qual = 1'b0;
            if (all_diff) begin
                m_lev[c] = ~m_lev[c];
                lu[c]    = ec;
                qual     = m_lev[c] ? edge_mode[2*c] : edge_mode[2*c+1];
            end
            if (qual) begin
                m_flag[c] = 1'b1;
                lq[c]     = ec;
            end else if (evt_clr[c]) begin
                m_flag[c] = 1'b0;
            end
            m_pulse[c] = (ec - lq[c] < PW);
        end
    endtask

    // One clock: model update at the edge, compare just after it.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        $display("t=%0t ec=%0d in=%h mode=%h clr=%h lvl=%h pls=%h flg=%h",
                 $time, ec, noisy_in, edge_mode, evt_clr, level_out, pulse_out, evt_flag);
        chk("pulse", pulse_out, m_pulse);
        chk("level", level_out, m_lev);
        chk("flag",  evt_flag,  m_flag);
    endtask

    int pc[NCH];

    initial begin
        // 1. Reset with inputs high, then release.
        rst_n     = 1'b0;
        noisy_in  = '1;
        edge_mode = 8'h55;
        evt_clr   = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_level", level_out, 0);
        chk("rst_pulse", pulse_out, 0);
        chk("rst_flag",  evt_flag,  0);
        rst_n = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            step();
            if (e < 6) begin
                chk("t1_quiet_level", level_out, 0);
                chk("t1_quiet_pulse", pulse_out, 0);
            end else begin
                chk("t1_pulse", pulse_out, 4'hF);
                chk("t1_level", level_out, 4'hF);
                chk("t1_flag",  evt_flag,  4'hF);
            end
        end
        step();
        chk("t1_pulse_after", pulse_out, (PW > 1) ? 4'hF : 4'h0);

        // 2. Glitch rejection, then a just-long-enough high.
        noisy_in = '0;
        repeat (12) step();
        evt_clr = '1;
        step();
        evt_clr = '0;
        chk("t2_flags_cleared", evt_flag, 0);
        noisy_in[0] = 1'b1;
        repeat (3) step();
        noisy_in[0] = 1'b0;
        repeat (10) step();
        chk("t2_glitch_level", level_out[0], 0);
        chk("t2_glitch_flag",  evt_flag[0],  0);
        noisy_in[0] = 1'b1;
        repeat (4) step();
        noisy_in[0] = 1'b0;
        step();
        chk("t2_k4_level", level_out[0], 0);
        step();
        chk("t2_k5_level", level_out[0], 1);
        chk("t2_k5_pulse", pulse_out[0], 1);
        repeat (10) step();

        // 3. Edge modes: ch0 rise, ch1 fall, ch2 both, ch3 off.
        edge_mode = 8'b00_11_10_01;
        for (int c = 0; c < NCH; c++) pc[c] = 0;
        noisy_in = 4'b1110;
        for (int i = 0; i < 20; i++) begin
            if (i == 10) begin
                chk("t3_level_high", level_out, 4'hE);
                noisy_in = '0;
            end
            step();
            for (int c = 0; c < NCH; c++) pc[c] += int'(pulse_out[c]);
        end
        chk("t3_level_low",    level_out, 0);
        chk("t3_pulses_ch1",   pc[1], PW);
        chk("t3_pulses_ch2",   pc[2], 2 * PW);
        chk("t3_pulses_ch3",   pc[3], 0);
        chk("t3_flag_ch3_off", evt_flag[3], 0);

        // 4. Flag handshake, including set coinciding with clear.
        edge_mode = 8'h55;
        evt_clr = '1;
        step();
        evt_clr = '0;
        noisy_in[0] = 1'b1;
        repeat (6) step();
        chk("t4_flag_set", evt_flag[0], 1);
        evt_clr[0] = 1'b1;
        step();
        evt_clr[0] = 1'b0;
        chk("t4_flag_clr", evt_flag[0], 0);
        edge_mode[1:0] = 2'b11;
        noisy_in[0] = 1'b0;
        repeat (5) step();
        evt_clr[0] = 1'b1;
        step();
        evt_clr[0] = 1'b0;
        chk("t4_set_wins",   evt_flag[0],  1);
        chk("t4_fall_pulse", pulse_out[0], 1);
        repeat (3) step();

        // 5. Asynchronous reset while ch0 is mid-count.
        edge_mode = 8'h55;
        noisy_in  = 4'hE;
        repeat (10) step();
        noisy_in[0] = 1'b1;
        repeat (4) step();
        #3;
        rst_n = 1'b0;
        #1;
        chk("t5_async_level", level_out, 0);
        chk("t5_async_flag",  evt_flag,  0);
        chk("t5_async_pulse", pulse_out, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        for (int e = 1; e <= 6; e++) begin
            step();
            if (e == 5) chk("t5_restart_quiet", level_out, 0);
            if (e == 6) chk("t5_restart_level", level_out, 4'hF);
        end

        // Randomized phase against the model.
        edge_mode = 8'($urandom);
        for (int i = 0; i < 800; i++) begin
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 5) == 0) noisy_in[c] = ~noisy_in[c];
                evt_clr[c] = ($urandom_range(0, 7) == 0);
            end
            if ($urandom_range(0, 49) == 0) edge_mode = 8'($urandom);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
